// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase encoding,
// direction constants and the Gray-code step helpers.
package quad_pkg;

  // Phase states named by the filtered {A,B} level they represent.
  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P11 = 2'b11,
    P10 = 2'b10
  } phase_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Successor of a phase in the up sequence P00->P01->P11->P10->P00.
  function automatic phase_t next_up(input phase_t ph);
    phase_t nxt;
    case (ph)
      P00:     nxt = P01;
      P01:     nxt = P11;
      P11:     nxt = P10;
      default: nxt = P00;
    endcase
    return nxt;
  endfunction

  // Successor of a phase in the down sequence (inverse of next_up).
  function automatic phase_t next_dn(input phase_t ph);
    phase_t nxt;
    case (ph)
      P00:     nxt = P10;
      P10:     nxt = P11;
      P11:     nxt = P01;
      default: nxt = P00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side bundle: raw phases and enable in, count commands and
// position out. The decoder is the slave; the driver of the pins is master.
interface quad_decoder_if #(
  parameter int CNT_W = 4
);
  logic             a;
  logic             b;
  logic             en;
  logic             step;
  logic             u_d;
  logic             err;
  logic [CNT_W-1:0] pos;

  modport master (
    output a, b, en,
    input  step, u_d, err, pos
  );

  modport slave (
    input  a, b, en,
    output step, u_d, err, pos
  );
endinterface

// File: rtl/quad_filt.sv
// One encoder channel: multi-flop synchroniser followed by a glitch filter
// that only accepts a new level after it has been stable for FILT samples.
module quad_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3
) (
  input  logic clk,
  input  logic rst,     // asynchronous, active-low
  input  logic din,     // raw asynchronous pin
  input  logic load,    // force level from the synchroniser output
  input  logic run,     // filter active (after priming)
  output logic synced,  // synchroniser output
  output logic level    // filtered level
);

  localparam int CW = $clog2(FILT + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  // Count consecutive samples that disagree with the filtered level; accept on the FILT-th.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (load) begin
      cnt_reg   <= '0;
      level_reg <= synced;
    end else if (run && (synced != level_reg)) begin
      if (cnt_reg == CW'(FILT - 1)) begin
        cnt_reg   <= '0;
        level_reg <= synced;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters the A/B phases, tracks the Gray-code phase and
// issues one-cycle step/err pulses plus a wrap-around position count.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  quad_decoder_if.slave  bus
);

  localparam int PW = $clog2(SYNC_STAGES + 1);

  logic          sync_a, sync_b;
  logic          filt_a, filt_b;
  logic          load;
  logic          primed_reg;
  logic [PW-1:0] prime_cnt_reg;

  phase_t           state_reg, state_next;
  phase_t           cur_in;
  logic             step_reg, step_next;
  logic             err_reg, err_next;
  logic             u_d_reg, u_d_next;
  logic [CNT_W-1:0] pos_reg, pos_next;

  quad_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.a),
    .load   (load),
    .run    (primed_reg),
    .synced (sync_a),
    .level  (filt_a)
  );

  quad_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.b),
    .load   (load),
    .run    (primed_reg),
    .synced (sync_b),
    .level  (filt_b)
  );

  // The synchroniser is full of valid samples once SYNC_STAGES edges have passed.
  assign load   = !primed_reg && (prime_cnt_reg == PW'(SYNC_STAGES));
  assign cur_in = phase_t'({filt_a, filt_b});

  // Wait for the synchronisers to fill after reset, then mark the decoder primed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_cnt_reg <= '0;
      primed_reg    <= 1'b0;
    end else if (!primed_reg) begin
      if (load) primed_reg    <= 1'b1;
      else      prime_cnt_reg <= prime_cnt_reg + PW'(1);
    end
  end

  // Phase state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= P00;
      step_reg  <= 1'b0;
      err_reg   <= 1'b0;
      u_d_reg   <= DIR_UP;
      pos_reg   <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      err_reg   <= err_next;
      u_d_reg   <= u_d_next;
      pos_reg   <= pos_next;
    end
  end

  // Classify each filtered phase change as up, down or illegal.
  always_comb begin
    state_next = state_reg;
    step_next  = 1'b0;
    err_next   = 1'b0;
    u_d_next   = u_d_reg;
    pos_next   = pos_reg;
    if (load) begin
      // Adopt the current pin levels as the reference phase without counting.
      state_next = phase_t'({sync_a, sync_b});
    end else if (primed_reg && (cur_in != state_reg)) begin
      state_next = cur_in;
      if (cur_in == next_up(state_reg)) begin
        if (bus.en) begin
          step_next = 1'b1;
          u_d_next  = DIR_UP;
          pos_next  = pos_reg + CNT_W'(1);
        end
      end else if (cur_in == next_dn(state_reg)) begin
        if (bus.en) begin
          step_next = 1'b1;
          u_d_next  = DIR_DN;
          pos_next  = pos_reg - CNT_W'(1);
        end
      end else begin
        // Both phases moved together: direction is unknowable.
        err_next = 1'b1;
      end
    end
  end

  assign bus.step = step_reg;
  assign bus.err  = err_reg;
  assign bus.u_d  = u_d_reg;
  assign bus.pos  = pos_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder (CNT_W=4, SYNC_STAGES=2, FILT=3).
module tb_quad_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  quad_decoder_if #(.CNT_W(4)) bus ();

  quad_decoder #(.CNT_W(4), .SYNC_STAGES(2), .FILT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive A/B at a negedge and hold for 'cycles' clocks, sampling on each
  // following negedge. Offsets count posedges from the first sampling edge (0).
  task automatic hold(input logic av, input logic bv, input int cycles,
                      output int ns, output int ne, output int fs,
                      output int fe, output int nb);
    ns = 0; ne = 0; fs = -1; fe = -1; nb = 0;
    bus.a = av;
    bus.b = bv;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.step === 1'b1) begin
        ns++;
        if (fs < 0) fs = i;
      end
      if (bus.err === 1'b1) begin
        ne++;
        if (fe < 0) fe = i;
      end
      if (bus.step === 1'b1 && bus.err === 1'b1) nb++;
    end
    $display("[TB] hold ab=%b%b cycles=%0d steps=%0d errs=%0d first_step=%0d pos=%0d u_d=%b",
             av, bv, cycles, ns, ne, fs, bus.pos, bus.u_d);
  endtask

  // Assert reset with the given pin levels, release it, and let priming finish.
  task automatic do_reset(input logic av, input logic bv);
    int ns, ne, fs, fe, nb;
    rst = 1'b0;
    bus.a = av;
    bus.b = bv;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hold(av, bv, 8, ns, ne, fs, fe, nb);
  endtask

  task automatic test_reset();
    int ns, ne, fs, fe, nb;
    rst = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b1;
    bus.en = 1'b1;
    #1;
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", bus.step); end
    tests++; if (bus.err  !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
    tests++; if (bus.pos  !== 4'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", bus.pos); end
    tests++; if (bus.u_d  !== 1'b1) begin fails++; $display("FAIL reset_u_d: got %b want 1", bus.u_d); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hold(1'b0, 1'b1, 10, ns, ne, fs, fe, nb);
    tests++; if (ns !== 0) begin fails++; $display("FAIL prime_steps: got %0d want 0", ns); end
    tests++; if (ne !== 0) begin fails++; $display("FAIL prime_errs: got %0d want 0", ne); end
    tests++; if (bus.pos !== 4'd0) begin fails++; $display("FAIL prime_pos: got %0d want 0", bus.pos); end
    tests++; if (bus.u_d !== 1'b1) begin fails++; $display("FAIL prime_u_d: got %b want 1", bus.u_d); end
    // From P01, moving to 11 is a legal up step (from P00 it would be an error).
    hold(1'b1, 1'b1, 10, ns, ne, fs, fe, nb);
    tests++; if (ns !== 1 || ne !== 0) begin fails++; $display("FAIL prime_phase01: steps=%0d errs=%0d want 1/0", ns, ne); end
    tests++; if (bus.pos !== 4'd1) begin fails++; $display("FAIL prime_phase_pos: got %0d want 1", bus.pos); end
  endtask

  task automatic test_up();
    int ns, ne, fs, fe, nb;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hold(seq[i][1], seq[i][0], 10, ns, ne, fs, fe, nb);
      tests++; if (ns !== 1) begin fails++; $display("FAIL up%0d_steps: got %0d want 1", i, ns); end
      tests++; if (fs !== 5) begin fails++; $display("FAIL up%0d_latency: got %0d want 5", i, fs); end
      tests++; if (bus.pos !== 4'(i + 1)) begin fails++; $display("FAIL up%0d_pos: got %0d want %0d", i, bus.pos, i + 1); end
    end
    tests++; if (bus.u_d !== 1'b1) begin fails++; $display("FAIL up_u_d: got %b want 1", bus.u_d); end
  endtask

  task automatic test_wrap();
    int ns, ne, fs, fe, nb;
    int idx;
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    do_reset(1'b0, 1'b0);
    hold(1'b1, 1'b0, 10, ns, ne, fs, fe, nb);
    tests++; if (ns !== 1) begin fails++; $display("FAIL wrap_dn_steps: got %0d want 1", ns); end
    tests++; if (bus.pos !== 4'd15) begin fails++; $display("FAIL wrap_dn_pos: got %0d want 15", bus.pos); end
    tests++; if (bus.u_d !== 1'b0) begin fails++; $display("FAIL wrap_dn_u_d: got %b want 0", bus.u_d); end
    idx = 3;
    for (int i = 0; i < 16; i++) begin
      idx = (idx + 1) % 4;
      hold(seq[idx][1], seq[idx][0], 8, ns, ne, fs, fe, nb);
      tests++;
      if (ns !== 1 || bus.pos !== 4'(i)) begin
        fails++; $display("FAIL wrap_up%0d: steps=%0d pos=%0d want 1/%0d", i, ns, bus.pos, i);
      end
    end
    tests++; if (bus.pos !== 4'd15) begin fails++; $display("FAIL wrap_final_pos: got %0d want 15", bus.pos); end
    tests++; if (bus.u_d !== 1'b1) begin fails++; $display("FAIL wrap_final_u_d: got %b want 1", bus.u_d); end
  endtask

  task automatic test_glitch();
    int ns, ne, fs, fe, nb;
    do_reset(1'b0, 1'b0);
    hold(1'b1, 1'b0, 2, ns, ne, fs, fe, nb);
    hold(1'b0, 1'b0, 12, ns, ne, fs, fe, nb);
    tests++; if (ns !== 0 || ne !== 0) begin fails++; $display("FAIL glitch2_reject: steps=%0d errs=%0d want 0/0", ns, ne); end
    tests++; if (bus.pos !== 4'd0) begin fails++; $display("FAIL glitch2_pos: got %0d want 0", bus.pos); end
    // A 3-cycle pulse is accepted (down step), then its release is a second, up step.
    hold(1'b1, 1'b0, 3, ns, ne, fs, fe, nb);
    tests++; if (ns !== 0) begin fails++; $display("FAIL pulse3_early: got %0d want 0", ns); end
    hold(1'b0, 1'b0, 12, ns, ne, fs, fe, nb);
    tests++; if (ns !== 2) begin fails++; $display("FAIL pulse3_steps: got %0d want 2", ns); end
    tests++; if (fs !== 2) begin fails++; $display("FAIL pulse3_latency: got %0d want 2", fs); end
    tests++; if (bus.pos !== 4'd0 || bus.u_d !== 1'b1) begin fails++; $display("FAIL pulse3_final: pos=%0d u_d=%b want 0/1", bus.pos, bus.u_d); end
  endtask

  task automatic test_illegal();
    int ns, ne, fs, fe, nb;
    int both;
    both = 0;
    do_reset(1'b0, 1'b0);
    hold(1'b1, 1'b0, 10, ns, ne, fs, fe, nb); both += nb;
    hold(1'b1, 1'b1, 10, ns, ne, fs, fe, nb); both += nb;
    tests++; if (bus.pos !== 4'd14 || bus.u_d !== 1'b0) begin fails++; $display("FAIL ill_setup: pos=%0d u_d=%b want 14/0", bus.pos, bus.u_d); end
    hold(1'b0, 1'b0, 10, ns, ne, fs, fe, nb); both += nb;
    tests++; if (ne !== 1 || ns !== 0) begin fails++; $display("FAIL ill_11_00: errs=%0d steps=%0d want 1/0", ne, ns); end
    tests++; if (fe !== 5) begin fails++; $display("FAIL ill_err_latency: got %0d want 5", fe); end
    tests++; if (bus.pos !== 4'd14 || bus.u_d !== 1'b0) begin fails++; $display("FAIL ill_hold: pos=%0d u_d=%b want 14/0", bus.pos, bus.u_d); end
    hold(1'b1, 1'b1, 10, ns, ne, fs, fe, nb); both += nb;
    tests++; if (ne !== 1 || ns !== 0) begin fails++; $display("FAIL ill_00_11: errs=%0d steps=%0d want 1/0", ne, ns); end
    tests++; if (bus.pos !== 4'd14 || bus.u_d !== 1'b0) begin fails++; $display("FAIL ill_hold2: pos=%0d u_d=%b want 14/0", bus.pos, bus.u_d); end
    hold(1'b1, 1'b0, 10, ns, ne, fs, fe, nb); both += nb;
    tests++; if (ns !== 1 || ne !== 0) begin fails++; $display("FAIL ill_recover: steps=%0d errs=%0d want 1/0", ns, ne); end
    tests++; if (bus.pos !== 4'd15 || bus.u_d !== 1'b1) begin fails++; $display("FAIL ill_recover_out: pos=%0d u_d=%b want 15/1", bus.pos, bus.u_d); end
    tests++; if (both !== 0) begin fails++; $display("FAIL step_err_overlap: got %0d want 0", both); end
  endtask

  task automatic test_enable();
    int ns, ne, fs, fe, nb;
    int total;
    total = 0;
    do_reset(1'b0, 1'b0);
    bus.en = 1'b0;
    hold(1'b0, 1'b1, 10, ns, ne, fs, fe, nb); total += ns;
    hold(1'b1, 1'b1, 10, ns, ne, fs, fe, nb); total += ns;
    hold(1'b1, 1'b0, 10, ns, ne, fs, fe, nb); total += ns;
    tests++; if (total !== 0) begin fails++; $display("FAIL en0_steps: got %0d want 0", total); end
    tests++; if (bus.pos !== 4'd0 || bus.u_d !== 1'b1) begin fails++; $display("FAIL en0_hold: pos=%0d u_d=%b want 0/1", bus.pos, bus.u_d); end
    hold(1'b0, 1'b1, 10, ns, ne, fs, fe, nb);
    tests++; if (ne !== 1 || ns !== 0) begin fails++; $display("FAIL en0_err: errs=%0d steps=%0d want 1/0", ne, ns); end
    bus.en = 1'b1;
    hold(1'b1, 1'b1, 10, ns, ne, fs, fe, nb);
    tests++; if (ns !== 1 || bus.pos !== 4'd1) begin fails++; $display("FAIL en1_step: steps=%0d pos=%0d want 1/1", ns, bus.pos); end
    // Reset while the 11->10 change is still inside the filter window.
    hold(1'b1, 1'b0, 4, ns, ne, fs, fe, nb);
    rst = 1'b0;
    #1;
    tests++; if (bus.pos !== 4'd0) begin fails++; $display("FAIL midrst_pos: got %0d want 0", bus.pos); end
    tests++; if (bus.step !== 1'b0 || bus.err !== 1'b0 || bus.u_d !== 1'b1) begin
      fails++; $display("FAIL midrst_outs: step=%b err=%b u_d=%b want 0/0/1", bus.step, bus.err, bus.u_d);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 1'b0, 15, ns, ne, fs, fe, nb);
    tests++; if (ns !== 0 || ne !== 0) begin fails++; $display("FAIL midrst_release: steps=%0d errs=%0d want 0/0", ns, ne); end
    tests++; if (bus.pos !== 4'd0) begin fails++; $display("FAIL midrst_release_pos: got %0d want 0", bus.pos); end
  endtask

  initial begin
    bus.a  = 1'b0;
    bus.b  = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);
    test_reset();
    test_up();
    test_wrap();
    test_glitch();
    test_illegal();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
